demux_1to2_reg: RTL and testbench

- Registered 1-to-2 demultiplexer with valid/ready handshakes; the steering counterpart to the 2-to-1 select mux.
- Accepts one word per cycle on a single input channel and routes it to output channel 0 or 1 according to select_i.
- Each output holds the word in its own buffer until that consumer takes it.
- Used wherever one producer feeds two pipeline consumers, e.g. splitting memory responses between the fetch side and the data side.

---
 rtl/demux_1to2_pkg.sv | 15 +
 rtl/demux_chan_buf.sv | 106 ++++++++++
 rtl/demux_1to2_reg.sv | 56 +++++
 tb/tb_demux_1to2_reg.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1to2_pkg.sv
// Shared types and constants for the registered 1-to-2 demultiplexer.
// DEMUX_1TO2_SKID_EN adds a second (skid) entry per channel and uses StTwo.
package demux_1to2_pkg;

  // The base build uses only StEmpty and StOne (FULL).
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } chan_state_e;

  localparam int unsigned CH0 = 0;
  localparam int unsigned CH1 = 1;

endpackage

// File: rtl/demux_chan_buf.sv
// One output channel buffer of the demux: registered word plus valid/ready handshake.
// With DEMUX_1TO2_SKID_EN defined a skid entry decouples can_push from ready_i.
module demux_chan_buf
  import demux_1to2_pkg::*;
#(
  parameter int unsigned size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  logic [size-1:0] push_data,
  output logic            can_push,
  output logic [size-1:0] data_o,
  output logic            valid_o,
  input  logic            ready_i
);

  chan_state_e     state_q, state_d;
  logic [size-1:0] data_q, data_d;
  logic            pop;

  assign valid_o = (state_q != StEmpty);
  assign data_o  = data_q;
  assign pop     = valid_o && ready_i;

`ifdef DEMUX_1TO2_SKID_EN
  logic [size-1:0] skid_q, skid_d;

  // Registered-only ready: no combinational path back from the consumer.
  assign can_push = (state_q != StTwo);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          state_d = StOne;
          data_d  = push_data;
        end
      end
      StOne: begin
        if (push && pop) begin
          data_d = push_data;
        end else if (push) begin
          state_d = StTwo;
          skid_d  = push_data;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          state_d = StOne;
          data_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_q <= '0;
    end else begin
      skid_q <= skid_d;
    end
  end
`else
  assign can_push = !valid_o || ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          state_d = StOne;
          data_d  = push_data;
        end
      end
      StOne: begin
        // Simultaneous drain and load reloads the register and stays full.
        if (push) begin
          data_d = push_data;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted word to channel select_i.
// Define DEMUX_1TO2_SKID_EN to give each channel a skid entry (see demux_chan_buf).
module demux_1to2_reg
  import demux_1to2_pkg::*;
#(
  parameter int unsigned size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic            select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic            valid0_o,
  input  logic            ready0_i,
  output logic [size-1:0] data1_o,
  output logic            valid1_o,
  input  logic            ready1_i
);

  logic [1:0] can_push;
  logic [1:0] push;

  // Only the selected channel can block the input.
  assign ready_o   = select_i ? can_push[CH1] : can_push[CH0];
  assign push[CH0] = valid_i && ready_o && !select_i;
  assign push[CH1] = valid_i && ready_o && select_i;

  demux_chan_buf #(
    .size(size)
  ) u_chan0 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (push[CH0]),
    .push_data(data_i),
    .can_push (can_push[CH0]),
    .data_o   (data0_o),
    .valid_o  (valid0_o),
    .ready_i  (ready0_i)
  );

  demux_chan_buf #(
    .size(size)
  ) u_chan1 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (push[CH1]),
    .push_data(data_i),
    .can_push (can_push[CH1]),
    .data_o   (data1_o),
    .valid_o  (valid1_o),
    .ready_i  (ready1_i)
  );

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Self-checking bench for demux_1to2_reg: directed scenarios plus a per-channel scoreboard.
// Inputs change 1 time unit after posedge; the monitor samples on negedge.
module tb_demux_1to2_reg;

  localparam int unsigned size = 32;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [size-1:0] data_i;
  logic            select_i;
  logic            valid_i;
  logic            ready_o;
  logic [size-1:0] data0_o;
  logic            valid0_o;
  logic            ready0_i;
  logic [size-1:0] data1_o;
  logic            valid1_o;
  logic            ready1_i;

  int checks = 0;
  int errors = 0;

  logic [size-1:0] exp0[$];
  logic [size-1:0] exp1[$];

  always #5 clk = ~clk;

  demux_1to2_reg #(
    .size(size)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .select_i(select_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data0_o (data0_o),
    .valid0_o(valid0_o),
    .ready0_i(ready0_i),
    .data1_o (data1_o),
    .valid1_o(valid1_o),
    .ready1_i(ready1_i)
  );

  // Monitor: values seen at negedge are those present at the following posedge.
  initial begin : monitor
    logic            stall_q;
    logic [size-1:0] stall_data;
    logic            stall_sel;
    logic [size-1:0] e;
    stall_q = 1'b0;
    stall_data = '0;
    stall_sel = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        exp0.delete();
        exp1.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          checks++;
          if (!valid_i || data_i !== stall_data || select_i !== stall_sel) begin
            errors++;
            $display("FAIL producer_rule: valid_i=%b data_i=%h select_i=%b, required 1 %h %b",
                     valid_i, data_i, select_i, stall_data, stall_sel);
          end
        end
        stall_q = valid_i && !ready_o;
        stall_data = data_i;
        stall_sel = select_i;
        // Drain before load so a same-edge reload compares against the older word.
        if (valid0_o && ready0_i) begin
          checks++;
          if (exp0.size() == 0) begin
            errors++;
            $display("FAIL sb_ch0: got %h, required no output", data0_o);
          end else begin
            e = exp0.pop_front();
            if (data0_o !== e) begin
              errors++;
              $display("FAIL sb_ch0: got %h, required %h", data0_o, e);
            end
          end
        end
        if (valid1_o && ready1_i) begin
          checks++;
          if (exp1.size() == 0) begin
            errors++;
            $display("FAIL sb_ch1: got %h, required no output", data1_o);
          end else begin
            e = exp1.pop_front();
            if (data1_o !== e) begin
              errors++;
              $display("FAIL sb_ch1: got %h, required %h", data1_o, e);
            end
          end
        end
        if (valid_i && ready_o) begin
          if (select_i) exp1.push_back(data_i);
          else exp0.push_back(data_i);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    valid_i = 1'b0;
    select_i = 1'b0;
    data_i = '0;
    ready0_i = 1'b0;
    ready1_i = 1'b0;
    step();
    step();
    checks++;
    if (valid0_o !== 1'b0 || valid1_o !== 1'b0 || data0_o !== '0 || data1_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: v0=%b v1=%b d0=%h d1=%h, required all zero",
               valid0_o, valid1_o, data0_o, data1_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", ready_o);
    end
    rst_i = 1'b0;
    step();
    data_i = 32'hDEADBEEF;
    select_i = 1'b0;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    checks++;
    if (valid0_o !== 1'b1 || data0_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_preload: v0=%b d0=%h, required 1 deadbeef", valid0_o, data0_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (valid0_o !== 1'b0 || data0_o !== '0) begin
      errors++;
      $display("FAIL reset_async: v0=%b d0=%h, required 0 0", valid0_o, data0_o);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1", ready_o);
    end
    step();
  endtask

  task automatic test_single();
    data_i = 32'h12345678;
    select_i = 1'b1;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    checks++;
    if (valid1_o !== 1'b1 || data1_o !== 32'h12345678 || valid0_o !== 1'b0) begin
      errors++;
      $display("FAIL single_present: v1=%b d1=%h v0=%b, required 1 12345678 0",
               valid1_o, data1_o, valid0_o);
    end
    repeat (3) step();
    checks++;
    if (valid1_o !== 1'b1 || data1_o !== 32'h12345678) begin
      errors++;
      $display("FAIL single_hold: v1=%b d1=%h, required 1 12345678", valid1_o, data1_o);
    end
    ready1_i = 1'b1;
    step();
    checks++;
    if (valid1_o !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: v1=%b, required 0", valid1_o);
    end
    ready1_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    ready0_i = 1'b1;
    select_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_i = 32'(i);
      valid_i = 1'b1;
      #1;
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b, required 1", i, ready_o);
      end
      step();
      checks++;
      if (valid0_o !== 1'b1 || data0_o !== 32'(i)) begin
        errors++;
        $display("FAIL b2b_data[%0d]: v0=%b d0=%h, required 1 %h", i, valid0_o, data0_o, i);
      end
    end
    valid_i = 1'b0;
    step();
    checks++;
    if (valid0_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained: v0=%b, required 0", valid0_o);
    end
    ready0_i = 1'b0;
  endtask

  task automatic test_stall_isolation();
    bit accepted;
    ready1_i = 1'b0;
    ready0_i = 1'b1;
    data_i = 32'hC;
    select_i = 1'b1;
    valid_i = 1'b1;
    step();
`ifdef DEMUX_1TO2_SKID_EN
    data_i = 32'hD;
    step();
`endif
    data_i = 32'hA;
    select_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL iso_ch0_ready: got %b, required 1", ready_o);
    end
    step();
    checks++;
    if (valid0_o !== 1'b1 || data0_o !== 32'hA) begin
      errors++;
      $display("FAIL iso_ch0_data: v0=%b d0=%h, required 1 0000000a", valid0_o, data0_o);
    end
    data_i = 32'hB;
    select_i = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (ready_o !== 1'b0) begin
        errors++;
        $display("FAIL iso_ch1_blocked: got %b, required 0", ready_o);
      end
      step();
    end
    ready1_i = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 5 && !accepted; k++) begin
      #1;
      if (ready_o === 1'b1) accepted = 1'b1;
      step();
    end
    valid_i = 1'b0;
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL iso_ch1_accept: got no acceptance, required acceptance within 5 cycles");
    end
    repeat (3) step();
    checks++;
    if (valid1_o !== 1'b0 || valid0_o !== 1'b0) begin
      errors++;
      $display("FAIL iso_drained: v0=%b v1=%b, required 0 0", valid0_o, valid1_o);
    end
    ready1_i = 1'b0;
    ready0_i = 1'b0;
  endtask

  task automatic test_simultaneous();
    ready0_i = 1'b0;
    data_i = 32'h1;
    select_i = 1'b0;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    checks++;
    if (valid0_o !== 1'b1 || data0_o !== 32'h1) begin
      errors++;
      $display("FAIL simul_first: v0=%b d0=%h, required 1 00000001", valid0_o, data0_o);
    end
    ready0_i = 1'b1;
    data_i = 32'h2;
    valid_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL simul_ready: got %b, required 1", ready_o);
    end
    step();
    valid_i = 1'b0;
    checks++;
    if (valid0_o !== 1'b1 || data0_o !== 32'h2) begin
      errors++;
      $display("FAIL simul_reload: v0=%b d0=%h, required 1 00000002", valid0_o, data0_o);
    end
    step();
    checks++;
    if (valid0_o !== 1'b0 || data0_o !== 32'h2) begin
      errors++;
      $display("FAIL simul_drain: v0=%b d0=%h, required 0 00000002", valid0_o, data0_o);
    end
    ready0_i = 1'b0;
  endtask

  task automatic test_capacity();
    ready0_i = 1'b0;
    select_i = 1'b0;
    data_i = 32'h1;
    valid_i = 1'b1;
    step();
`ifdef DEMUX_1TO2_SKID_EN
    data_i = 32'h2;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL skid_second_ready: got %b, required 1", ready_o);
    end
    step();
    valid_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL skid_third_ready: got %b, required 0", ready_o);
    end
    ready0_i = 1'b1;
    checks++;
    if (valid0_o !== 1'b1 || data0_o !== 32'h1) begin
      errors++;
      $display("FAIL skid_out1: v0=%b d0=%h, required 1 00000001", valid0_o, data0_o);
    end
    step();
    checks++;
    if (valid0_o !== 1'b1 || data0_o !== 32'h2) begin
      errors++;
      $display("FAIL skid_out2: v0=%b d0=%h, required 1 00000002", valid0_o, data0_o);
    end
    step();
`else
    data_i = 32'h2;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_blocked: got %b, required 0", ready_o);
    end
    ready0_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL full_comb_ready: got %b, required 1", ready_o);
    end
    step();
    valid_i = 1'b0;
    checks++;
    if (valid0_o !== 1'b1 || data0_o !== 32'h2) begin
      errors++;
      $display("FAIL full_reload: v0=%b d0=%h, required 1 00000002", valid0_o, data0_o);
    end
    step();
`endif
    checks++;
    if (valid0_o !== 1'b0) begin
      errors++;
      $display("FAIL capacity_drained: v0=%b, required 0", valid0_o);
    end
    ready0_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall_isolation();
    test_simultaneous();
    test_capacity();
    repeat (2) step();
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: ch0=%0d ch1=%0d words pending, required 0 0",
               exp0.size(), exp1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
